cpu_bus_arbiter: RTL and testbench
==================================

Name: cpu_bus_arbiter

Overview:
- Shares the CPU's external data bus (o_bus_clk/o_bus_we/o_bus_addr/o_bus_data, i_bus_data/i_bus_data_ready) between two requesters.
  - Port 0: the CPU core's load/store sequencer.
  - Port 1: a secondary master, e.g. a DMA or video fetch engine.
- Round-robin arbitration, one transaction at a time.
- Sequences the bus strobe and waits for the device's ready.
- Times out on unresponsive devices.
- Sits between the cpu top level and the bus fabric/peripheral decoder.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
TIMEOUT, 255, max WAIT cycles before abort (1..255)
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
i_cpu_clk  in  1  single clock, all logic rising-edge
i_rst  in  1  synchronous active-high reset
i_req0 / i_req1  in  1  transaction request, port 0/1
i_we0 / i_we1  in  1  1=write, 0=read
i_addr0 / i_addr1  in  ADDR_W  address
i_wdata0 / i_wdata1  in  DATA_W  write data
o_ack0 / o_ack1  out  1  one-cycle completion pulse
o_rdata0 / o_rdata1  out  DATA_W  read data, valid while matching ack=1
o_err  out  1  pulses with ack when transaction timed out
o_busy  out  1  1 when state != IDLE
o_grant  out  1  port currently/last granted
o_timeouts  out  8  saturating timeout count
o_bus_clk  out  1  bus strobe
o_bus_we  out  1  bus write enable
o_bus_addr  out  ADDR_W  bus address
o_bus_data  out  DATA_W  bus write data
i_bus_data  in  DATA_W  bus read data
i_bus_data_ready  in  1  device completion

Behaviour:
- Reset is synchronous active-high on i_cpu_clk; i_rst is the clock and reset naming already used by cpu.
- Reset values:
  - state=IDLE; all acks, o_err, o_busy, o_bus_clk, o_bus_we = 0.
  - o_bus_addr, o_bus_data, o_rdata0/1 = 0; o_timeouts = 0.
  - o_grant = 1, so port 0 wins the first contention.
- Reset mid-transaction aborts immediately: no ack, no err, strobe dropped the same edge.
- All outputs are registered.
- FSM states and transitions:
  - IDLE:
    - No req: stay.
    - One req: grant it.
    - Both: grant the port != o_grant (round-robin).
    - On grant: latch addr/we/wdata into o_bus_*, set o_grant, go to SETUP.
  - SETUP: o_bus_clk=0 for one cycle (address/data setup); go to STROBE.
  - STROBE: o_bus_clk=1; load timeout counter with TIMEOUT; go to WAIT.
  - WAIT: o_bus_clk stays 1.
    - i_bus_data_ready=1: capture i_bus_data into o_rdata[grant] (reads only; writes leave rdata unchanged); go to ACK.
    - Else if counter==0: o_rdata[grant]=ERR_DATA (reads), set err flag, o_timeouts+=1 saturating at 255; go to ACK.
    - Else: counter-=1.
  - ACK:
    - o_bus_clk=0, o_bus_we=0.
    - o_ack[grant]=1 for exactly this cycle; o_err=1 iff timed out.
    - Go to IDLE.
- i_bus_data_ready is ignored outside WAIT.
- Latency:
  - Ready already high on entering WAIT: ack appears 4 cycles after the IDLE cycle in which req was sampled.
  - Worst case: 4+TIMEOUT cycles.
- Requester handshake:
  - Hold req/we/addr/wdata stable until ack.
  - Deassert req in the cycle after ack, or keep it high to issue a back-to-back transaction. IDLE re-arbitrates, so an alternate requester gets the next slot.
  - Fields are latched at grant, so a req dropped after grant does not abort: the transaction completes and the ack is emitted.
- Non-granted port: ack=0 and its rdata is held.
- Throughput: minimum 5 cycles per transaction (IDLE, SETUP, STROBE, WAIT, ACK).

Test Plan:
- Reset, then i_req0=1 read addr 0x0000_1234; device ready in first WAIT cycle with data 0xA5A5_0001 -> o_bus_addr=0x1234 from SETUP; o_bus_clk high in STROBE/WAIT; o_ack0 pulses 4 cycles after req sampled; o_rdata0=0xA5A5_0001; o_err=0.
- i_req0 and i_req1 both held high, with a ready device -> grants alternate 0,1,0,1; each ack pulses once on its own port; o_grant toggles every transaction.
- i_req1 write addr 0x10, data 0xCAFEF00D, ready delayed 3 cycles -> o_bus_we=1, o_bus_data=0xCAFEF00D through WAIT; o_ack1 after ready; o_rdata1 unchanged; o_bus_we=0 in ACK.
- TIMEOUT=4, read with ready never asserted -> ack after exactly 5 WAIT cycles; o_err=1; o_rdata=0xDEADBEEF; o_timeouts=1. Repeat 300x -> o_timeouts saturates at 255.
- i_rst pulsed while in WAIT -> next cycle o_bus_clk=0, o_busy=0, no ack; first post-reset contention grants port 0.
- i_bus_data_ready held high during IDLE/SETUP/STROBE -> ignored; capture occurs only in WAIT; o_rdata matches i_bus_data in that cycle.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// Two-port round-robin arbiter for the CPU external data bus.
// Runs one strobed transaction at a time and aborts with an error if the device never responds.
module cpu_bus_arbiter #(
    parameter int unsigned         ADDR_W   = 32,
    parameter int unsigned         DATA_W   = 32,
    parameter int unsigned         TIMEOUT  = 255,
    parameter logic [DATA_W-1:0]   ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_grant,
    output logic [7:0]        o_timeouts,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_data_ready
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_ACK
    } state_e;

    state_e              state_q;
    logic                ack0_q;
    logic                ack1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                err_q;
    logic                busy_q;
    logic                grant_q;
    logic [CNT_W-1:0]    timeouts_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                bus_clk_q;
    logic                bus_we_q;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_data_q;

    // Port to grant this cycle: the sole requester, or the one not served last under contention.
    logic grant_sel_c;
    assign grant_sel_c = (i_req0 && i_req1) ? ~grant_q : i_req1;

    // Read data returned to the requester at completion: device data, or the error word on timeout.
    logic [DATA_W-1:0] done_rdata_c;
    assign done_rdata_c = i_bus_data_ready ? i_bus_data : ERR_DATA;

    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= 1'b1;
            timeouts_q <= '0;
            cnt_q      <= '0;
            bus_clk_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_req0 || i_req1) begin
                        grant_q    <= grant_sel_c;
                        bus_we_q   <= grant_sel_c ? i_we1    : i_we0;
                        bus_addr_q <= grant_sel_c ? i_addr1  : i_addr0;
                        bus_data_q <= grant_sel_c ? i_wdata1 : i_wdata0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    bus_clk_q <= 1'b1;
                    state_q   <= S_STROBE;
                end
                S_STROBE: begin
                    cnt_q   <= CNT_W'(TIMEOUT);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_bus_data_ready || (cnt_q == '0)) begin
                        if (!bus_we_q) begin
                            if (grant_q) rdata1_q <= done_rdata_c;
                            else         rdata0_q <= done_rdata_c;
                        end
                        if (!i_bus_data_ready) begin
                            err_q <= 1'b1;
                            if (timeouts_q != {CNT_W{1'b1}}) timeouts_q <= timeouts_q + CNT_W'(1);
                        end
                        ack0_q    <= ~grant_q;
                        ack1_q    <= grant_q;
                        bus_clk_q <= 1'b0;
                        bus_we_q  <= 1'b0;
                        state_q   <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    bus_clk_q <= 1'b0;
                    bus_we_q  <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ack0     = ack0_q;
    assign o_ack1     = ack1_q;
    assign o_rdata0   = rdata0_q;
    assign o_rdata1   = rdata1_q;
    assign o_err      = err_q;
    assign o_busy     = busy_q;
    assign o_grant    = grant_q;
    assign o_timeouts = timeouts_q;
    assign o_bus_clk  = bus_clk_q;
    assign o_bus_we   = bus_we_q;
    assign o_bus_addr = bus_addr_q;
    assign o_bus_data = bus_data_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed-vector bench for cpu_bus_arbiter, built with a short timeout so aborts are quick to reach.
module tb_cpu_bus_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              err, busy, grant;
    logic [7:0]        timeouts;
    logic              bus_clk, bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data_o;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ready;

    int errors = 0;
    int checks = 0;

    cpu_bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (4),
        .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .i_cpu_clk       (clk),
        .i_rst           (rst),
        .i_req0          (req0),
        .i_req1          (req1),
        .i_we0           (we0),
        .i_we1           (we1),
        .i_addr0         (addr0),
        .i_addr1         (addr1),
        .i_wdata0        (wdata0),
        .i_wdata1        (wdata1),
        .o_ack0          (ack0),
        .o_ack1          (ack1),
        .o_rdata0        (rdata0),
        .o_rdata1        (rdata1),
        .o_err           (err),
        .o_busy          (busy),
        .o_grant         (grant),
        .o_timeouts      (timeouts),
        .o_bus_clk       (bus_clk),
        .o_bus_we        (bus_we),
        .o_bus_addr      (bus_addr),
        .o_bus_data      (bus_data_o),
        .i_bus_data      (bus_rdata),
        .i_bus_data_ready(bus_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read on port 0 with the device silent; reports cycles from the IDLE sample to ack.
    task automatic timeout_txn(output int n, output logic e, output logic [31:0] rd);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0040; bus_ready = 1'b0;
        n = 0; e = 1'b0; rd = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n++;
            if (ack0) begin
                e  = err;
                rd = rdata0;
                break;
            end
        end
        req0 = 1'b0;
        tick();
    endtask

    logic [31:0] exp_rd0, exp_rd1;
    logic        exp_g;
    logic [31:0] dval;
    int          n;
    logic        e;
    logic [31:0] rd;

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        bus_rdata = '0; bus_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        check("rst_busy",     32'(busy), 32'd0);
        check("rst_ack",      32'({ack1, ack0}), 32'd0);
        check("rst_grant",    32'(grant), 32'd1);
        check("rst_bus_clk",  32'(bus_clk), 32'd0);
        check("rst_bus_we",   32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_rdata0",   rdata0, 32'd0);
        check("rst_timeouts", 32'(timeouts), 32'd0);

        // Basic read with the device already ready.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_1234;
        bus_ready = 1'b1; bus_rdata = 32'hA5A5_0001;
        tick();
        check("rd_setup_addr", bus_addr, 32'h0000_1234);
        check("rd_setup_clk",  32'(bus_clk), 32'd0);
        check("rd_setup_busy", 32'(busy), 32'd1);
        check("rd_setup_grant", 32'(grant), 32'd0);
        tick();
        check("rd_strobe_clk", 32'(bus_clk), 32'd1);
        tick();
        check("rd_wait_clk", 32'(bus_clk), 32'd1);
        check("rd_wait_ack", 32'(ack0), 32'd0);
        tick();
        check("rd_ack0",   32'(ack0), 32'd1);
        check("rd_ack1",   32'(ack1), 32'd0);
        check("rd_rdata0", rdata0, 32'hA5A5_0001);
        check("rd_err",    32'(err), 32'd0);
        check("rd_ack_clk", 32'(bus_clk), 32'd0);
        req0 = 1'b0;
        tick();
        check("rd_idle_ack",  32'(ack0), 32'd0);
        check("rd_idle_busy", 32'(busy), 32'd0);

        // Ready held high outside WAIT: only the value present in WAIT is captured.
        bus_ready = 1'b1; bus_rdata = 32'h1111_1111;
        tick();
        check("ign_idle_busy", 32'(busy), 32'd0);
        check("ign_idle_ack",  32'(ack0), 32'd0);
        req0 = 1'b1; addr0 = 32'h0000_0020;
        tick();
        bus_rdata = 32'h2222_2222;
        tick();
        bus_rdata = 32'h3333_3333;
        tick();
        bus_rdata = 32'h4444_4444;
        check("ign_wait_ack", 32'(ack0), 32'd0);
        tick();
        check("ign_ack0",   32'(ack0), 32'd1);
        check("ign_rdata0", rdata0, 32'h4444_4444);
        req0 = 1'b0;
        tick();

        // Contention: grants alternate, each ack on its own port, the other rdata held.
        exp_rd0 = 32'h4444_4444; exp_rd1 = 32'd0; exp_g = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h0000_0100; addr1 = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            exp_g = ~exp_g;
            dval  = 32'hB000_0000 + 32'(k);
            bus_rdata = dval;
            tick();
            check("rr_grant", 32'(grant), 32'(exp_g));
            check("rr_addr",  bus_addr, exp_g ? 32'h0000_0200 : 32'h0000_0100);
            tick(); tick(); tick();
            if (exp_g) exp_rd1 = dval;
            else       exp_rd0 = dval;
            check("rr_acks", 32'({ack1, ack0}), exp_g ? 32'd2 : 32'd1);
            check("rr_rdata0", rdata0, exp_rd0);
            check("rr_rdata1", rdata1, exp_rd1);
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick();
        end

        // Write on port 1 with the device answering after three WAIT cycles.
        bus_ready = 1'b0; bus_rdata = 32'h7777_7777;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0010; wdata1 = 32'hCAFE_F00D;
        tick();
        check("wr_setup_we",   32'(bus_we), 32'd1);
        check("wr_setup_data", bus_data_o, 32'hCAFE_F00D);
        tick(); tick(); tick(); tick();
        check("wr_wait_we",   32'(bus_we), 32'd1);
        check("wr_wait_clk",  32'(bus_clk), 32'd1);
        check("wr_wait_data", bus_data_o, 32'hCAFE_F00D);
        check("wr_wait_ack",  32'(ack1), 32'd0);
        bus_ready = 1'b1;
        tick();
        check("wr_ack1",   32'(ack1), 32'd1);
        check("wr_err",    32'(err), 32'd0);
        check("wr_ack_we", 32'(bus_we), 32'd0);
        check("wr_rdata1", rdata1, exp_rd1);
        check("wr_tmo",    32'(timeouts), 32'd0);
        req1 = 1'b0; we1 = 1'b0; bus_ready = 1'b0;
        tick();

        // Unresponsive device: 4 + TIMEOUT cycles to ack, error data, saturating count.
        timeout_txn(n, e, rd);
        check("tmo_latency", 32'(n), 32'd8);
        check("tmo_err",     32'(e), 32'd1);
        check("tmo_rdata",   rd, 32'hDEADBEEF);
        check("tmo_count1",  32'(timeouts), 32'd1);
        for (int k = 1; k < 300; k++) timeout_txn(n, e, rd);
        check("tmo_last_err", 32'(e), 32'd1);
        check("tmo_saturate", 32'(timeouts), 32'd255);

        // Reset while in WAIT aborts at once and restores port-0 priority.
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0300; bus_ready = 1'b0;
        tick(); tick(); tick();
        check("rw_in_wait", 32'(bus_clk), 32'd1);
        rst = 1'b1;
        tick();
        check("rw_bus_clk", 32'(bus_clk), 32'd0);
        check("rw_busy",    32'(busy), 32'd0);
        check("rw_acks",    32'({ack1, ack0}), 32'd0);
        check("rw_err",     32'(err), 32'd0);
        check("rw_tmo",     32'(timeouts), 32'd0);
        rst = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0400;
        tick();
        check("rw_grant0", 32'(grant), 32'd0);
        check("rw_addr",   bus_addr, 32'h0000_0400);
        bus_ready = 1'b1; bus_rdata = 32'h5A5A_5A5A;
        tick(); tick(); tick();
        check("rw_ack0",   32'(ack0), 32'd1);
        check("rw_rdata0", rdata0, 32'h5A5A_5A5A);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
